// File: rtl/axis_packet_source.sv
// AXI-Stream packet generator: each accepted length/seed command becomes one framed
// packet of cmd_len+1 beats carrying an incrementing data pattern.
module axis_packet_source #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [DATA_WIDTH-1:0] cmd_seed,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  pkt_done,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic [CNT_WIDTH-1:0]  pkt_count
);

  typedef enum logic {StIdle, StSend} state_e;

  state_e                state_q;
  logic                  tvalid_q;
  logic                  tlast_q;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic [LEN_WIDTH-1:0]  remain_q;
  logic                  pkt_done_q;
  logic [CNT_WIDTH-1:0]  beat_count_q;
  logic [CNT_WIDTH-1:0]  pkt_count_q;

  logic beat_fire;
  logic last_fire;
  logic cmd_fire;

  assign beat_fire = tvalid_q && m_axis_tready;
  assign last_fire = beat_fire && tlast_q;
  // A new command is taken only while idle or as the final beat leaves.
  assign cmd_ready = (state_q == StIdle) || last_fire;
  assign cmd_fire  = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tdata_q      <= '0;
      remain_q     <= '0;
      pkt_done_q   <= 1'b0;
      beat_count_q <= '0;
      pkt_count_q  <= '0;
    end else begin
      pkt_done_q <= last_fire;
      if (beat_fire) beat_count_q <= beat_count_q + 1'b1;
      if (last_fire) pkt_count_q  <= pkt_count_q + 1'b1;

      unique case (state_q)
        StIdle: begin
          if (cmd_fire) begin
            state_q  <= StSend;
            tvalid_q <= 1'b1;
            tdata_q  <= cmd_seed;
            remain_q <= cmd_len;
            tlast_q  <= (cmd_len == '0);
          end
        end
        StSend: begin
          if (beat_fire) begin
            if (!tlast_q) begin
              tdata_q  <= tdata_q + 1'b1;
              remain_q <= remain_q - 1'b1;
              tlast_q  <= (remain_q == LEN_WIDTH'(1));
            end else if (cmd_fire) begin
              // Back-to-back packet: no idle beat between frames.
              tdata_q  <= cmd_seed;
              remain_q <= cmd_len;
              tlast_q  <= (cmd_len == '0);
            end else begin
              state_q  <= StIdle;
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;
  assign busy          = tvalid_q;
  assign pkt_done      = pkt_done_q;
  assign beat_count    = beat_count_q;
  assign pkt_count     = pkt_count_q;

endmodule
